// File: rtl/captura_operandos.sv
// -----------------------------------------------------------------------------
// captura_operandos
//
// Operand-entry stage. It takes one-cycle key pulses plus a key code and
// builds two signed decimal operands, A then B, one digit at a time. The pair
// is then offered to the multiplier. The entry in progress is also exposed so
// the display stage can show it.
//
// Ports:
//   clk             system clock; all state updates on the rising edge
//   rst             asynchronous reset, active-high
//   tecla_pulso     one-cycle key-press strobe
//   tecla[3:0]      key code: 0-9 digit, A sign toggle, B clear entry,
//                   C enter, D-F no-op (sampled only with tecla_pulso)
//   operando_a      committed operand A (two's complement)
//   operando_b      committed operand B (two's complement)
//   valido          A/B are stable and offered downstream
//   listo           downstream accepts A/B
//   valor_entrada   signed value of the entry in progress
//   cuenta_digitos  digits entered in the current entry
//   sel_operando    0 = entering A, 1 = entering B or waiting in LISTO
//   estado_dbg      raw FSM state (0 CARGA_A, 1 CARGA_B, 2 LISTO)
//
// Handshake: valido is decoded from the state register only. It stays high
// until a rising edge sees valido & listo both high; that edge is the
// transfer. listo may be high before valido rises. There is no
// combinational path from listo to valido.
// -----------------------------------------------------------------------------
module captura_operandos #(
  parameter int WIDTH       = 8,
  parameter int MAX_DIGITOS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               tecla_pulso,
  input  logic [3:0]                         tecla,
  output logic [WIDTH-1:0]                   operando_a,
  output logic [WIDTH-1:0]                   operando_b,
  output logic                               valido,
  input  logic                               listo,
  output logic [WIDTH-1:0]                   valor_entrada,
  output logic [$clog2(MAX_DIGITOS+1)-1:0]   cuenta_digitos,
  output logic                               sel_operando,
  output logic [1:0]                         estado_dbg
);

  localparam int MW = WIDTH - 1;
  localparam int CW = $clog2(MAX_DIGITOS + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_DIGITOS);

  typedef enum logic [1:0] {
    CARGA_A = 2'd0,
    CARGA_B = 2'd1,
    LISTO   = 2'd2
  } estado_t;

  estado_t         estado, estado_d;
  logic [MW-1:0]   mag, mag_d;
  logic [CW-1:0]   cont, cont_d;
  logic            neg, neg_d;
  logic [WIDTH-1:0] op_a_d, op_b_d;
  logic [MW-1:0]   mag_mac;

  // mag*10 + d. The digit limit keeps this within MW bits, so no wider
  // intermediate is needed.
  assign mag_mac = (mag << 3) + (mag << 1) + MW'(tecla);

  // Subtracting from zero at full width makes -0 come out as 0.
  assign valor_entrada  = neg ? (WIDTH'(0) - {1'b0, mag}) : {1'b0, mag};
  assign cuenta_digitos = cont;
  assign valido         = (estado == LISTO);
  assign sel_operando   = (estado != CARGA_A);
  assign estado_dbg     = estado;

  always_comb begin
    estado_d = estado;
    mag_d    = mag;
    cont_d   = cont;
    neg_d    = neg;
    op_a_d   = operando_a;
    op_b_d   = operando_b;
    case (estado)
      CARGA_A, CARGA_B: begin
        if (tecla_pulso) begin
          if (tecla <= 4'h9) begin
            // Extra digits past the limit are silently dropped.
            if (cont < MAX_C) begin
              mag_d  = mag_mac;
              cont_d = cont + CW'(1);
            end
          end else begin
            case (tecla)
              4'hA: neg_d = ~neg;
              4'hB: begin
                mag_d  = '0;
                cont_d = '0;
                neg_d  = 1'b0;
              end
              4'hC: begin
                if (estado == CARGA_A) begin
                  op_a_d   = valor_entrada;
                  estado_d = CARGA_B;
                end else begin
                  op_b_d   = valor_entrada;
                  estado_d = LISTO;
                end
                mag_d  = '0;
                cont_d = '0;
                neg_d  = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
      LISTO: begin
        // Keys are ignored here, including one on the transfer edge.
        if (listo) estado_d = CARGA_A;
      end
      default: estado_d = CARGA_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado     <= CARGA_A;
      mag        <= '0;
      cont       <= '0;
      neg        <= 1'b0;
      operando_a <= '0;
      operando_b <= '0;
    end else begin
      estado     <= estado_d;
      mag        <= mag_d;
      cont       <= cont_d;
      neg        <= neg_d;
      operando_a <= op_a_d;
      operando_b <= op_b_d;
    end
  end

endmodule

// File: tb/tb_captura_operandos.sv
module tb_captura_operandos;

  localparam int WIDTH = 8;
  localparam int CW    = 2;

  logic             clk;
  logic             rst;
  logic             tecla_pulso;
  logic [3:0]       tecla;
  logic [WIDTH-1:0] operando_a;
  logic [WIDTH-1:0] operando_b;
  logic             valido;
  logic             listo;
  logic [WIDTH-1:0] valor_entrada;
  logic [CW-1:0]    cuenta_digitos;
  logic             sel_operando;
  logic [1:0]       estado_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int valido_ciclos = 0;
  logic valido_prev = 1'b0;

  // Expected {operando_a, operando_b} per offered pair.
  logic [2*WIDTH-1:0] exp_q[$];

  captura_operandos #(.WIDTH(WIDTH), .MAX_DIGITOS(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .tecla_pulso    (tecla_pulso),
    .tecla          (tecla),
    .operando_a     (operando_a),
    .operando_b     (operando_b),
    .valido         (valido),
    .listo          (listo),
    .valor_entrada  (valor_entrada),
    .cuenta_digitos (cuenta_digitos),
    .sel_operando   (sel_operando),
    .estado_dbg     (estado_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; leaves the pulse high for exactly one cycle.
  task automatic press(input logic [3:0] k);
    tecla_pulso = 1'b1;
    tecla       = k;
    @(posedge clk);
    #1;
    tecla_pulso = 1'b0;
    tecla       = 4'h0;
  endtask

  // One-cycle listo pulse while valido is up.
  task automatic handshake();
    listo = 1'b1;
    @(posedge clk);
    #1;
    listo = 1'b0;
    check("valido_after_xfer", {15'd0, valido}, 16'd0);
    check("sel_after_xfer", {15'd0, sel_operando}, 16'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (valido) valido_ciclos++;
      if (valido && !valido_prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got pair 0x%0h%0h, required none", operando_a, operando_b);
        end else begin
          logic [2*WIDTH-1:0] e;
          e = exp_q.pop_front();
          check("sb_pair", {operando_a, operando_b}, e);
        end
      end
      valido_prev = valido;
    end else begin
      valido_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    rst = 1'b1; listo = 1'b0; tecla_pulso = 1'b0; tecla = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_a", {8'd0, operando_a}, 16'd0);
    check("rst_valido", {15'd0, valido}, 16'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_op_a", {8'd0, operando_a}, 16'd0);
    check("idle_op_b", {8'd0, operando_b}, 16'd0);
    check("idle_valido", {15'd0, valido}, 16'd0);
    check("idle_sel", {15'd0, sel_operando}, 16'd0);
    check("idle_valor", {8'd0, valor_entrada}, 16'd0);
    check("idle_cuenta", {14'd0, cuenta_digitos}, 16'd0);

    // 42 and -7
    press(4'h4);
    check("d4_valor", {8'd0, valor_entrada}, 16'h0004);
    check("d4_cuenta", {14'd0, cuenta_digitos}, 16'd1);
    press(4'h2);
    check("d42_valor", {8'd0, valor_entrada}, 16'h002A);
    press(4'hC);
    check("commit_a42", {8'd0, operando_a}, 16'h002A);
    check("sel_b", {15'd0, sel_operando}, 16'd1);
    check("cuenta_clr", {14'd0, cuenta_digitos}, 16'd0);
    press(4'hA);
    check("neg0_valor", {8'd0, valor_entrada}, 16'd0);
    press(4'h7);
    check("m7_valor", {8'd0, valor_entrada}, 16'h00F9);
    press(4'hE);
    check("noop_valor", {8'd0, valor_entrada}, 16'h00F9);
    check("noop_cuenta", {14'd0, cuenta_digitos}, 16'd1);
    exp_q.push_back({8'h2A, 8'hF9});
    press(4'hC);
    check("valido_rise", {15'd0, valido}, 16'd1);
    repeat (3) @(posedge clk);
    #1;
    check("valido_held", {15'd0, valido}, 16'd1);
    press(4'h3);
    check("listo_key_ign", {14'd0, cuenta_digitos}, 16'd0);
    check("listo_hold_b", {8'd0, operando_b}, 16'h00F9);
    handshake();
    check("keep_a", {8'd0, operando_a}, 16'h002A);

    // digit limit, then A,A,C for B
    press(4'h9); press(4'h9); press(4'h5);
    check("lim_cuenta", {14'd0, cuenta_digitos}, 16'd2);
    check("lim_valor", {8'd0, valor_entrada}, 16'd99);
    press(4'hC);
    check("commit_a99", {8'd0, operando_a}, 16'd99);
    press(4'hA); press(4'hA);
    exp_q.push_back({8'd99, 8'd0});
    press(4'hC);
    handshake();

    // clear, then A,C for B (no -0)
    press(4'h3); press(4'hB);
    check("clr_valor", {8'd0, valor_entrada}, 16'd0);
    check("clr_cuenta", {14'd0, cuenta_digitos}, 16'd0);
    press(4'h8); press(4'hF); press(4'hC);
    check("commit_a8", {8'd0, operando_a}, 16'd8);
    press(4'hA);
    exp_q.push_back({8'd8, 8'd0});
    press(4'hC);
    check("no_neg_zero", {8'd0, operando_b}, 16'd0);
    handshake();

    // listo tied high: valido for exactly one cycle, key on transfer edge lost
    listo = 1'b1;
    press(4'h1); press(4'hC);
    press(4'hA); press(4'h2);
    check("m2_valor", {8'd0, valor_entrada}, 16'h00FE);
    exp_q.push_back({8'd1, 8'hFE});
    press(4'hC);
    v0 = valido_ciclos;
    press(4'h5);
    check("tied_valido_0", {15'd0, valido}, 16'd0);
    check("xfer_key_ign", {14'd0, cuenta_digitos}, 16'd0);
    check("xfer_sel", {15'd0, sel_operando}, 16'd0);
    @(posedge clk);
    #1;
    check("tied_one_cycle", 16'(valido_ciclos - v0), 16'd1);
    listo = 1'b0;

    // async reset mid-entry
    press(4'h1); press(4'h2); press(4'hA);
    check("m12_valor", {8'd0, valor_entrada}, 16'h00F4);
    #2 rst = 1'b1;
    #1;
    check("arst_op_a", {8'd0, operando_a}, 16'd0);
    check("arst_op_b", {8'd0, operando_b}, 16'd0);
    check("arst_valor", {8'd0, valor_entrada}, 16'd0);
    check("arst_cuenta", {14'd0, cuenta_digitos}, 16'd0);
    check("arst_sel", {15'd0, sel_operando}, 16'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_state", {14'd0, estado_dbg}, 16'd0);
    press(4'h5);
    check("post_rst_valor", {8'd0, valor_entrada}, 16'd5);
    press(4'hC);
    check("post_rst_a5", {8'd0, operando_a}, 16'd5);
    check("post_rst_sel", {15'd0, sel_operando}, 16'd1);

    repeat (2) @(posedge clk);
    check("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
